// File: rtl/chu_gpo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chu_gpo_pkg
// Description : Shared register map and FSM state type for the chu_gpo_pulse
//               general-purpose output core.
// Revision    : 1.0 - initial release
// ============================================================================
package chu_gpo_pkg;

    // Slot register map (word address on the 5-bit slot address bus)
    localparam logic [4:0] REG_DATA  = 5'd0;
    localparam logic [4:0] REG_SET   = 5'd1;
    localparam logic [4:0] REG_CLR   = 5'd2;
    localparam logic [4:0] REG_TOG   = 5'd3;
    localparam logic [4:0] REG_PLEN  = 5'd4;
    localparam logic [4:0] REG_PULSE = 5'd5;
    localparam logic [4:0] REG_CTRL  = 5'd6;
    localparam logic [4:0] REG_DOUT  = 5'd7;
    localparam logic [4:0] REG_CNT   = 5'd8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } gpo_state_t;

endpackage
`default_nettype wire

// File: rtl/gpo_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module      : gpo_pulse_timer
// Description : One-shot pulse timer. A start request in IDLE with a nonzero
//               length loads the down-counter and enters ACTIVE; the timer
//               returns to IDLE on the edge where the count leaves 1, or at
//               once on abort. Start requests while ACTIVE are ignored.
// Ports       : clk    - system clock
//               rst    - synchronous active-high reset
//               start  - launch request (honoured only in IDLE, len != 0)
//               abort  - terminate an active pulse on this edge
//               len    - pulse length in clock cycles
//               active - high while the pulse is running
//               cnt    - remaining cycles of the running pulse (0 in IDLE)
// Revision    : 1.0 - initial release
// ============================================================================
module gpo_pulse_timer
    import chu_gpo_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] len,
    output logic             active,
    output logic [CNT_W-1:0] cnt
);

    gpo_state_t       r_state;
    gpo_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (start && (len != '0)) begin
                    w_state_nxt = ACTIVE;
                    w_cnt_nxt   = len;
                end
            end
            ACTIVE: begin
                // Terminating at cnt<=1 (not just ==1) keeps the counter
                // from ever wrapping even if it were somehow zero here.
                if (abort || (r_cnt <= CNT_W'(1))) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign active = (r_state == ACTIVE);
    assign cnt    = r_cnt;

endmodule
`default_nettype wire

// File: rtl/chu_gpo_pulse.sv
`default_nettype none
// ============================================================================
// Module      : chu_gpo_pulse
// Description : MMIO general-purpose output core. Software writes the pin
//               word directly or via set/clear/toggle, and can launch a
//               hardware-timed one-shot that inverts selected pins for a
//               programmed number of clock cycles. dout = data ^ mask, both
//               registered, so the pins never glitch.
// Ports       : clk     - system clock
//               rst     - synchronous active-high reset
//               cs      - slot select
//               read    - read strobe (no side effects)
//               write   - write strobe, effective when cs && write
//               addr    - register address
//               wr_data - write data (bits above W ignored for pin registers)
//               rd_data - combinational read data, zero-extended
//               dout    - output pins
// Revision    : 1.0 - initial release
// ============================================================================
module chu_gpo_pulse
    import chu_gpo_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic [W-1:0] dout
);

    logic [W-1:0]     r_data;
    logic [W-1:0]     r_mask;
    logic [CNT_W-1:0] r_plen;

    logic             w_wr;
    logic [W-1:0]     w_wr_pins;
    logic             w_pulse_wr;
    logic             w_abort;
    logic             w_start;
    logic             w_active;
    logic [CNT_W-1:0] w_cnt;
    logic             w_pulse_end;
    logic [W-1:0]     w_dout;
    logic             w_unused;

    assign w_wr       = cs && write;
    assign w_wr_pins  = wr_data[W-1:0];
    assign w_pulse_wr = w_wr && (addr == REG_PULSE);
    assign w_abort    = w_wr && (addr == REG_CTRL) && wr_data[0];

    // Qualified launch: only from IDLE, with something to invert and a
    // nonzero length. Anything else leaves the mask untouched.
    assign w_start    = w_pulse_wr && !w_active && (w_wr_pins != '0) && (r_plen != '0);

    // Mirrors the timer's termination condition so the mask drops on the
    // same edge the timer returns to IDLE.
    assign w_pulse_end = w_active && (w_abort || (w_cnt <= CNT_W'(1)));

    gpo_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (w_start),
        .abort  (w_abort),
        .len    (r_plen),
        .active (w_active),
        .cnt    (w_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_plen <= '0;
        end else if (w_wr) begin
            case (addr)
                REG_DATA: r_data <= w_wr_pins;
                REG_SET:  r_data <= r_data | w_wr_pins;
                REG_CLR:  r_data <= r_data & ~w_wr_pins;
                REG_TOG:  r_data <= r_data ^ w_wr_pins;
                REG_PLEN: r_plen <= wr_data[CNT_W-1:0];
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
        end else if (w_start) begin
            r_mask <= w_wr_pins;
        end else if (w_pulse_end) begin
            r_mask <= '0;
        end
    end

    assign w_dout = r_data ^ r_mask;
    assign dout   = w_dout;

    always_comb begin
        rd_data = '0;
        case (addr)
            REG_DATA: rd_data[W-1:0]     = r_data;
            REG_PLEN: rd_data[CNT_W-1:0] = r_plen;
            REG_CTRL: rd_data[1]         = w_active;
            REG_DOUT: rd_data[W-1:0]     = w_dout;
            REG_CNT:  rd_data[CNT_W-1:0] = w_cnt;
            default:  ;
        endcase
    end

    // read has no side effects; upper wr_data bits are intentionally dropped.
    assign w_unused = ^{read, wr_data};

endmodule
`default_nettype wire

// File: tb/tb_chu_gpo_pulse.sv
`default_nettype none
// ============================================================================
// Module      : tb_chu_gpo_pulse
// Description : Directed self-checking bench for chu_gpo_pulse (W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chu_gpo_pulse;

    logic        clk;
    logic        rst;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [7:0]  dout;

    int checks;
    int errors;

    chu_gpo_pulse #(
        .W     (8),
        .CNT_W (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .dout    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        cs      = 1'b1;
        write   = 1'b1;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        #1;
        cs      = 1'b0;
        write   = 1'b0;
        wr_data = 32'h0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        read = 1'b1;
        #1;
        check(tag, rd_data, exp);
        read = 1'b0;
    endtask

    task automatic check_dout(input string tag, input logic [7:0] exp);
        check(tag, {24'h0, dout}, {24'h0, exp});
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        cs      = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = 5'd0;
        wr_data = 32'h0;
        tick();
        tick();
        check_dout("reset_dout", 8'h00);
        check_reg("reset_busy", 5'd6, 32'h0);
        rst = 1'b0;

        // Reset in the middle of a pulse
        bus_write(5'd4, 32'd100);
        bus_write(5'd5, 32'hFF);
        check_dout("pre_rst_pulse", 8'hFF);
        check_reg("pre_rst_busy", 5'd6, 32'h2);
        rst = 1'b1;
        tick();
        check_dout("midrst_dout", 8'h00);
        check_reg("midrst_busy", 5'd6, 32'h0);
        check_reg("midrst_cnt", 5'd8, 32'h0);
        tick();
        rst = 1'b0;
        check_reg("midrst_plen", 5'd4, 32'h0);

        // Bit operations
        bus_write(5'd0, 32'hA5);
        check_dout("data_a5", 8'hA5);
        bus_write(5'd1, 32'h0F);
        check_dout("set_0f", 8'hAF);
        bus_write(5'd2, 32'hA0);
        check_dout("clr_a0", 8'h0F);
        bus_write(5'd3, 32'hFF);
        check_dout("tog_ff", 8'hF0);
        check_reg("rd_dout", 5'd7, 32'hF0);
        bus_write(5'd0, 32'h1234_5600);
        check_dout("data_upper_dropped", 8'h00);
        check_reg("rd_data_zext", 5'd0, 32'h0);
        check_reg("rd_unmapped", 5'd9, 32'h0);

        // Pulse timing: 0x81 inverted for exactly 5 cycles
        bus_write(5'd4, 32'd5);
        check_reg("rd_plen", 5'd4, 32'd5);
        bus_write(5'd5, 32'h81);
        for (int i = 0; i < 5; i++) begin
            check_dout("pulse_on", 8'h81);
            check_reg("pulse_cnt", 5'd8, 32'(5 - i));
            tick();
        end
        check_dout("pulse_off", 8'h00);
        check_reg("pulse_off_busy", 5'd6, 32'h0);
        check_reg("pulse_off_cnt", 5'd8, 32'h0);

        // Rejected launches
        bus_write(5'd4, 32'd0);
        bus_write(5'd5, 32'hFF);
        check_dout("rej_plen0", 8'h00);
        check_reg("rej_plen0_busy", 5'd6, 32'h0);
        bus_write(5'd4, 32'd10);
        bus_write(5'd5, 32'h00);
        check_dout("rej_mask0", 8'h00);
        check_reg("rej_mask0_busy", 5'd6, 32'h0);
        bus_write(5'd4, 32'd4);
        bus_write(5'd5, 32'h01);
        check_dout("retrig_first", 8'h01);
        bus_write(5'd5, 32'h02);
        check_dout("retrig_ignored", 8'h01);
        check_reg("retrig_cnt", 5'd8, 32'd3);
        tick();
        check_dout("retrig_c2", 8'h01);
        tick();
        check_dout("retrig_c1", 8'h01);
        tick();
        check_dout("retrig_end", 8'h00);

        // Data write during a pulse
        bus_write(5'd4, 32'd8);
        bus_write(5'd5, 32'h0F);
        check_dout("inter_start", 8'h0F);
        tick();
        tick();
        bus_write(5'd0, 32'hFF);
        check_dout("inter_data", 8'hF0);
        check_reg("inter_cnt", 5'd8, 32'd5);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_dout("inter_hold", 8'hF0);
        end
        tick();
        check_dout("inter_end", 8'hFF);

        // Abort, PLEN update while active, relaunch
        bus_write(5'd4, 32'd1000);
        bus_write(5'd5, 32'h3C);
        check_dout("abort_start", 8'hC3);
        repeat (10) tick();
        check_reg("abort_cnt10", 5'd8, 32'd990);
        bus_write(5'd4, 32'd3);
        check_reg("plen_active_cnt", 5'd8, 32'd989);
        check_reg("plen_active_plen", 5'd4, 32'd3);
        bus_write(5'd6, 32'h1);
        check_dout("abort_dout", 8'hFF);
        check_reg("abort_busy", 5'd6, 32'h0);
        check_reg("abort_cnt", 5'd8, 32'h0);
        bus_write(5'd5, 32'h3C);
        check_dout("relaunch_dout", 8'hC3);
        check_reg("relaunch_busy", 5'd6, 32'h2);
        check_reg("relaunch_cnt", 5'd8, 32'd3);
        tick();
        tick();
        check_dout("relaunch_c1", 8'hC3);
        tick();
        check_dout("relaunch_end", 8'hFF);
        check_reg("relaunch_idle", 5'd6, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
